// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with register-array storage, combinational head read
// and an explicit occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty decode the count register, so they reflect pre-edge state.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter fed by the data-memory UART store strobe;
// bytes are queued in a FIFO and sent back-to-back with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        din,
    input  logic               we,
    output logic               txd,
    output logic               tx_busy,
    output logic               fifo_full,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int unsigned BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLK_DIV - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          baud_end;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          unused_hi;

    assign unused_hi = ^din[31:8];

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (we),
        .pop   (pop),
        .din   (din[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign txd     = txd_q;
    assign tx_busy = (state_q != IDLE) || !fifo_empty;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        pop      = 1'b0;
        baud_end = (baud_q == '0);
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = BAUD_MAX;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    baud_d  = BAUD_MAX;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = BAUD_MAX;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        state_d = STOP;
                        bit_d   = '0;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        txd_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = BAUD_MAX;
                    if (bit_q != LAST_STOP) begin
                        bit_d = bit_q + 1'b1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle cycle between frames.
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            overflow <= overflow | (we & fifo_full);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a line
// monitor decodes 8N1 frames cycle by cycle and checks them against the queue.
module tb_uart_tx;

    localparam int CDIV = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] din   = '0;
    logic        we_a  = 1'b0;
    logic        we_b  = 1'b0;
    logic        use_b = 1'b0;

    logic       txd_a, busy_a, full_a, ovf_a;
    logic [4:0] cnt_a;
    logic       txd_b, busy_b, full_b, ovf_b;
    logic [2:0] cnt_b;
    logic       mon_line;

    logic [7:0] exp_q [$];
    int checks = 0;
    int passed = 0;
    int frames = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_DIV(CDIV), .FIFO_AW(4)) dut_a (
        .clk(clk), .reset(reset), .din(din), .we(we_a), .txd(txd_a),
        .tx_busy(busy_a), .fifo_full(full_a), .fifo_count(cnt_a), .overflow(ovf_a)
    );

    uart_tx #(.CLK_DIV(CDIV), .FIFO_AW(2)) dut_b (
        .clk(clk), .reset(reset), .din(din), .we(we_b), .txd(txd_b),
        .tx_busy(busy_b), .fifo_full(full_b), .fifo_count(cnt_b), .overflow(ovf_b)
    );

    assign mon_line = use_b ? txd_b : txd_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic quiet_check(input string name, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (txd_a !== 1'b1 || txd_b !== 1'b1) ok = 1'b0;
        end
        chk(name, ok, 1'b1);
    endtask

    initial begin : monitor
        logic [9:0] bits;
        logic       cur, shape_ok, aborted;
        logic [7:0] expb;
        forever begin
            @(negedge clk);
            if (reset && mon_line === 1'b0) begin
                shape_ok = 1'b1;
                aborted  = 1'b0;
                bits     = '0;
                cur      = 1'b0;
                for (int k = 0; k < 10 * CDIV; k++) begin
                    if (k != 0) @(negedge clk);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % CDIV == 0) begin
                        cur = mon_line;
                        bits[k / CDIV] = mon_line;
                    end else if (mon_line !== cur) begin
                        shape_ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    frames++;
                    chk("frame_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        expb = exp_q.pop_front();
                        chk("frame_byte", bits[8:1], expb);
                    end
                    chk("frame_shape", {shape_ok, bits[0], bits[9]}, 3'b101);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", checks);
        $fatal(1);
    end

    initial begin : stimulus
        int f0;

        // Reset state
        tick(3);
        chk("rst_txd", txd_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_count", cnt_a, 5'd0);
        chk("rst_full", full_a, 1'b0);
        chk("rst_overflow", ovf_a, 1'b0);
        reset = 1'b1;
        quiet_check("rst_quiet", 100);

        // Single byte 0x55
        f0 = frames;
        din = 32'h0000_0055; we_a = 1'b1; exp_q.push_back(8'h55);
        tick(1);
        we_a = 1'b0;
        chk("single_count_e0", cnt_a, 5'd1);
        tick(1);
        chk("single_start_low", txd_a, 1'b0);
        chk("single_count_e1", cnt_a, 5'd0);
        tick(39);
        chk("single_busy_c40", busy_a, 1'b1);
        tick(1);
        chk("single_busy_c41", busy_a, 1'b0);
        chk("single_frames", frames - f0, 1);

        // Upper bits ignored
        tick(2);
        din = 32'hDEAD_BE41; we_a = 1'b1; exp_q.push_back(8'h41);
        tick(1);
        we_a = 1'b0;
        tick(41);
        chk("upper_busy_done", busy_a, 1'b0);

        // Back-to-back 01 02 03
        tick(2);
        f0 = frames;
        din = 32'h01; we_a = 1'b1; exp_q.push_back(8'h01);
        tick(1);
        din = 32'h02; exp_q.push_back(8'h02);
        tick(1);
        din = 32'h03; exp_q.push_back(8'h03);
        tick(1);
        we_a = 1'b0;
        tick(118);
        chk("b2b_busy_c120", busy_a, 1'b1);
        tick(1);
        chk("b2b_busy_c121", busy_a, 1'b0);
        chk("b2b_frames", frames - f0, 3);

        // Overflow on the 4-entry instance
        tick(2);
        use_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = 32'hA0 + 32'(i); we_b = 1'b1;
            if (i < 5) exp_q.push_back(8'hA0 + 8'(i));
            tick(1);
            if (i == 1) chk("ovf_count_e1", cnt_b, 3'd1);
            if (i == 4) begin
                chk("ovf_count_e4", cnt_b, 3'd4);
                chk("ovf_full_e4", full_b, 1'b1);
                chk("ovf_flag_e4", ovf_b, 1'b0);
            end
        end
        we_b = 1'b0;
        chk("ovf_flag_e5", ovf_b, 1'b1);
        chk("ovf_count_e5", cnt_b, 3'd4);
        tick(200);
        chk("ovf_flag_sticky", ovf_b, 1'b1);
        chk("ovf_busy_done", busy_b, 1'b0);
        chk("ovf_drained", exp_q.size(), 0);
        use_b = 1'b0;

        // Reset during data bit 3 of 0x5A with two bytes queued
        tick(2);
        din = 32'h5A; we_a = 1'b1; exp_q.push_back(8'h5A);
        tick(1);
        din = 32'h11; exp_q.push_back(8'h11);
        tick(1);
        din = 32'h22; exp_q.push_back(8'h22);
        tick(1);
        we_a = 1'b0;
        tick(16);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_txd", txd_a, 1'b1);
        chk("midrst_count", cnt_a, 5'd0);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_overflow_b", ovf_b, 1'b0);
        tick(3);
        reset = 1'b1;
        quiet_check("midrst_quiet", 100);
        chk("midrst_count_after", cnt_a, 5'd0);

        f0 = frames;
        din = 32'h3C; we_a = 1'b1; exp_q.push_back(8'h3C);
        tick(1);
        we_a = 1'b0;
        tick(41);
        chk("post_rst_busy", busy_a, 1'b0);
        chk("post_rst_frames", frames - f0, 1);

        tick(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter at the far end of the data memory's UART store path.
- Consumes the 32-bit `uart_dout` word and the one-cycle `uart_we` strobe registered by the data memory on stores to 0x1000_0000.
- Buffers the low byte of each accepted word in a small FIFO and shifts it out on `txd` as 8N1 frames (1 start, 8 data LSB-first, 1 stop).
- Accepts one write per cycle with no back-pressure to the core; excess writes are dropped and flagged.

Parameters:
- `CLK_DIV`, 868: clock cycles per bit period; must be >= 2.
- `FIFO_AW`, 4: log2 of FIFO entries (default 16 entries).

Ports:
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset.
- `din`  input  32  write word; only `din[7:0]` is transmitted, `din[31:8]` ignored.
- `we`  input  1  write strobe, sampled on `posedge clk`.
- `txd`  output  1  serial line, idle high.
- `tx_busy`  output  1  high while a frame is in flight or the FIFO is non-empty.
- `fifo_full`  output  1  FIFO holds `2**FIFO_AW` entries.
- `fifo_count`  output  `FIFO_AW+1`  current FIFO occupancy.
- `overflow`  output  1  sticky; set when a write is dropped, cleared only by reset.

Behaviour:
- Reset (async assert, `reset`=0) forces these values immediately, including mid-frame:
  - `txd`=1, `tx_busy`=0, `fifo_full`=0, `fifo_count`=0, `overflow`=0.
  - FIFO pointers zeroed, FSM in IDLE, bit counter and baud counter cleared.
  - No partial frame resumes after reset release.
- FIFO write: when `we`=1 and `fifo_full`=0 at the edge, push `din[7:0]`.
- `fifo_full` and `fifo_count` are registered; full is evaluated on the pre-edge state.
  - `we` while full drops the byte and sets `overflow`, even if a pop happens on the same edge.
- Simultaneous push and pop on a non-full, non-empty FIFO: `fifo_count` unchanged.
- No bypass path: a byte written into an empty FIFO is poppable on the following edge.
- Pointers wrap modulo `2**FIFO_AW`; occupancy is tracked by a count register, not by pointer comparison.
- FSM states: IDLE, START, DATA, STOP. `txd` is registered.
  - IDLE: `txd`=1. If FIFO non-empty: pop the head into an 8-bit shift register, baud counter := `CLK_DIV`-1, go to START.
  - START: `txd`=0 for `CLK_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `txd`=`shift[0]` for `CLK_DIV` cycles per bit; shift right after each bit; after bit 7 go to STOP.
  - STOP: `txd`=1 for `CLK_DIV` cycles. At the end, if FIFO non-empty, pop and go directly to START (zero inter-frame gap); else go to IDLE.
- Baud counter counts down from `CLK_DIV`-1 to 0; reaching 0 advances the bit.
  - Counter width is `$clog2(CLK_DIV)`.
- Latency and timing:
  - `we` at edge E0 gives a pop at E1; `txd` falls after E1.
  - A frame is exactly 10*`CLK_DIV` cycles.
  - Back-to-back frames have a period of exactly 10*`CLK_DIV`.
- `tx_busy` = (state != IDLE) || (`fifo_count` != 0), registered-equivalent. It falls on the edge that returns the FSM to IDLE with an empty FIFO.

Decomposition:
- Package `uart_pkg`:
  - `uart_state_t` enum {IDLE, START, DATA, STOP}.
  - `localparam DATA_BITS` = 8.
  - `localparam STOP_BITS` = 1.
- One sub-module, `sync_fifo`:
  - Parameters WIDTH=8, AW.
  - Register-array storage, combinational head read, count register.
  - Ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`.
  - Same clk/reset convention (async active-low).
- `uart_tx` contains the baud counter, FSM, shift register and overflow flag.

Test Plan:
- Reset: hold `reset`=0 for 3 cycles -> `txd`=1, `tx_busy`=0, `fifo_count`=0, `overflow`=0; no line activity for 100 cycles after release.
- `CLK_DIV`=4, one write `din`=32'h0000_0055 at edge 0:
  - `txd` low cycles 1-4.
  - Then bits 1,0,1,0,1,0,1,0 for 4 cycles each.
  - Stop high cycles 37-40.
  - `tx_busy`=0 from cycle 41.
- Upper bits ignored: `din`=32'hDEAD_BE41 -> decoded byte 0x41, frame identical to a write of 32'h41.
- Back-to-back: writes 0x01, 0x02, 0x03 on consecutive edges, `CLK_DIV`=4 -> three contiguous frames totalling 120 cycles, no idle cycle between stop and next start, decoded 01 02 03.
- Overflow: `FIFO_AW`=2, six consecutive writes 0xA0..0xA5:
  - Edge 1 pops while pushing.
  - Count reaches 4 after edge 4.
  - Write 0xA5 at edge 5 is dropped; `overflow`=1 and stays 1.
  - Line carries A0..A4 only.
- Reset mid-frame: assert `reset` during data bit 3 of 0x5A with two bytes queued:
  - `txd`=1 immediately, `fifo_count`=0.
  - After release, no frames are sent.
  - A new write 0x3C transmits correctly.
